seq_div16x16: RTL and testbench
===============================

Name: seq_div16x16

Overview:
- Iterative 16/16 radix-2 restoring divider; the inverse-operation companion to booth16x16_top in the ALU datapath.
- Computes quotient and remainder, signed or unsigned, selected per operation by alu_signed.
- Multi-cycle with a start/busy/done handshake; results stay registered until the next accepted start.
- Flag outputs mirror the multiplier's neg_flag/zero_flag semantics.

Parameters:
- WIDTH, 16, operand, quotient and remainder width. Only 16 is verified.
- CNT_W, 5, iteration counter width. Must hold the value WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- A  input  16  dividend
- B  input  16  divisor
- alu_signed  input  1  1 = two's-complement operation, 0 = unsigned
- busy  output  1  high from the accepting edge until the edge that raises done
- done  output  1  one-cycle pulse; results valid from this cycle onward
- QUOT_RESULT  output  16  quotient, registered
- REM_RESULT  output  16  remainder, registered
- div_by_zero  output  1  B was 0 for the last operation
- overflow  output  1  signed 0x8000 / 0xFFFF for the last operation
- neg_flag  output  1  alu_signed & QUOT_RESULT[15]
- zero_flag  output  1  QUOT_RESULT == 0

Behaviour:
- Reset (rst=1 at a clk edge):
  - Go to IDLE.
  - All outputs = 0, including QUOT_RESULT and REM_RESULT.
  - Counter = 0.
  - Reset has priority in every state, including mid-CALC; the operation in flight is dropped.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - On an edge with start=1: latch A, B and alu_signed; set busy=1.
  - Clear div_by_zero and overflow.
  - If B==0, go to FIX with the dz path selected. Otherwise go to CALC with count=0.
  - Latch operand magnitudes: if alu_signed, |A| and |B|, with |0x8000| = 0x8000 treated as unsigned 16-bit. Otherwise A and B as-is.
  - Record sign_q = A[15]^B[15] and sign_r = A[15], both gated by alu_signed.
- CALC:
  - Exactly 16 edges. Each edge does one restoring step on a 17-bit partial remainder: shift left bringing in the next dividend MSB, trial-subtract the divisor magnitude, keep the result if non-negative, and shift the quotient bit in.
  - After the 16th step (count==15), go to FIX.
- FIX (one edge):
  - Normal path: QUOT_RESULT = sign_q ? -q : q and REM_RESULT = sign_r ? -r : r, both 16-bit truncated. Quotient truncates toward zero; the remainder takes the dividend's sign.
  - Divide-by-zero path: QUOT_RESULT=0xFFFF, REM_RESULT=A, div_by_zero=1.
  - overflow = alu_signed & A==0x8000 & B==0xFFFF. The result falls out naturally: Q=0x8000, R=0.
  - neg_flag and zero_flag are updated from the new QUOT_RESULT.
  - Go to DONE; busy stays 1.
- DONE (one cycle):
  - done=1 and busy=0 during this cycle.
  - Next edge returns to IDLE and clears done.
  - start is not sampled in DONE; a start must be held or re-asserted in IDLE.
- Latency, with edge 0 being the start-accepting edge:
  - Normal: FIX at edge 17, done high between edges 17 and 18.
  - Divide by zero: FIX at edge 1, done high between edges 1 and 2.
- start while busy (CALC/FIX) is ignored, with no queuing. Input changes during CALC have no effect.
- Results and flags hold their values through IDLE until the next FIX.
- Invariant: busy and done are never high together.

Test Plan:
- Unsigned 100/7, start for 1 cycle -> busy for 17 cycles, done at edge 17, Q=0x000E, R=0x0002, neg=0, zero=0.
- Signed 0xFFF9/0x0002 (-7/2) -> Q=0xFFFD, R=0xFFFF, neg_flag=1; unsigned same operands -> Q=0x7FFC, R=0x0001, neg_flag=0.
- Divide by zero, unsigned 0x1234/0 -> done at edge 1, Q=0xFFFF, R=0x1234, div_by_zero=1; the next normal op clears div_by_zero.
- Signed 0x8000/0xFFFF -> Q=0x8000, R=0, overflow=1, neg=1; unsigned same operands -> Q=0, R=0x8000, zero_flag=1, overflow=0.
- start re-pulsed at edge 5 of an op, rst=1 at edge 9 of the next -> first start ignored (single done, correct result); reset returns to IDLE with all outputs 0, no done pulse, and a new start afterwards completes normally.
- 500 random A/B/alu_signed ops, back-to-back start -> Q/R match $signed or unsigned / and % each time, done exactly once per accepted start.

Source files
------------

// File: rtl/seq_div16x16.sv
// Iterative radix-2 restoring divider, 16/16, signed or unsigned per operation.
// Start/busy/done handshake; quotient, remainder and flags stay registered until the next FIX.
module seq_div16x16 #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             alu_signed,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] QUOT_RESULT,
  output logic [WIDTH-1:0] REM_RESULT,
  output logic             div_by_zero,
  output logic             overflow,
  output logic             neg_flag,
  output logic             zero_flag
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  // Two's-complement negate when neg is set; |MIN_NEG| stays MIN_NEG as an unsigned magnitude.
  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic neg);
    logic [WIDTH-1:0] res;
    if (neg) begin
      res = ~v + WIDTH'(1);
    end else begin
      res = v;
    end
    return res;
  endfunction

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_dvd;      // dividend magnitude shifting out, quotient bits shifting in
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_a_raw;
  logic             r_sgn;
  logic             r_sign_q;
  logic             r_sign_r;
  logic             r_dz;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem_out;
  logic             r_div_by_zero;
  logic             r_overflow;
  logic             r_neg;
  logic             r_zero;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_rem_next;
  logic             w_q_bit;
  logic [WIDTH-1:0] w_quot_fix;
  logic [WIDTH-1:0] w_rem_fix;

  // One restoring step plus the sign fix-up applied in FIX.
  always_comb begin
    w_shift = {r_rem, r_dvd[WIDTH-1]};
    w_trial = w_shift - {1'b0, r_dvs};
    w_q_bit = ~w_trial[WIDTH];
    if (w_trial[WIDTH]) begin
      w_rem_next = w_shift[WIDTH-1:0];
    end else begin
      w_rem_next = w_trial[WIDTH-1:0];
    end
    if (r_dz) begin
      w_quot_fix = ALL_ONES;
      w_rem_fix  = r_a_raw;
    end else begin
      w_quot_fix = neg_if(r_dvd, r_sign_q);
      w_rem_fix  = neg_if(r_rem, r_sign_r);
    end
  end

  // Control FSM, datapath registers and registered results.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= {CNT_W{1'b0}};
      r_dvd         <= ZERO_W;
      r_dvs         <= ZERO_W;
      r_rem         <= ZERO_W;
      r_a_raw       <= ZERO_W;
      r_sgn         <= 1'b0;
      r_sign_q      <= 1'b0;
      r_sign_r      <= 1'b0;
      r_dz          <= 1'b0;
      r_ovf         <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_quot        <= ZERO_W;
      r_rem_out     <= ZERO_W;
      r_div_by_zero <= 1'b0;
      r_overflow    <= 1'b0;
      r_neg         <= 1'b0;
      r_zero        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_busy        <= 1'b1;
            r_div_by_zero <= 1'b0;
            r_overflow    <= 1'b0;
            r_a_raw       <= A;
            r_sgn         <= alu_signed;
            r_dvd         <= neg_if(A, alu_signed & A[WIDTH-1]);
            r_dvs         <= neg_if(B, alu_signed & B[WIDTH-1]);
            r_sign_q      <= alu_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
            r_sign_r      <= alu_signed & A[WIDTH-1];
            r_dz          <= (B == ZERO_W);
            r_ovf         <= alu_signed & (A == MIN_NEG) & (B == ALL_ONES);
            r_rem         <= ZERO_W;
            r_cnt         <= {CNT_W{1'b0}};
            if (B == ZERO_W) begin
              r_state <= S_FIX;
            end else begin
              r_state <= S_CALC;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_CALC: begin
          r_rem <= w_rem_next;
          r_dvd <= {r_dvd[WIDTH-2:0], w_q_bit};
          r_cnt <= r_cnt + ONE_CNT;
          if (r_cnt == LAST_CNT) begin
            r_state <= S_FIX;
          end else begin
            r_state <= S_CALC;
          end
        end
        S_FIX: begin
          r_quot        <= w_quot_fix;
          r_rem_out     <= w_rem_fix;
          r_div_by_zero <= r_dz;
          r_overflow    <= r_ovf;
          r_neg         <= r_sgn & w_quot_fix[WIDTH-1];
          r_zero        <= (w_quot_fix == ZERO_W);
          r_busy        <= 1'b0;
          r_done        <= 1'b1;
          r_state       <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign QUOT_RESULT = r_quot;
  assign REM_RESULT  = r_rem_out;
  assign div_by_zero = r_div_by_zero;
  assign overflow    = r_overflow;
  assign neg_flag    = r_neg;
  assign zero_flag   = r_zero;

endmodule

// File: tb/tb_seq_div16x16.sv
// Table-driven and hand-sequenced checks for seq_div16x16, plus a random sweep
// against the language's own / and % operators.
module tb_seq_div16x16;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        sgn_in;
  logic        busy;
  logic        done;
  logic [15:0] quot;
  logic [15:0] rem;
  logic        dz;
  logic        ovf;
  logic        neg;
  logic        zero;

  int n_cmp;
  int n_bad;
  int done_cnt;

  seq_div16x16 dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .A          (a_in),
    .B          (b_in),
    .alu_signed (sgn_in),
    .busy       (busy),
    .done       (done),
    .QUOT_RESULT(quot),
    .REM_RESULT (rem),
    .div_by_zero(dz),
    .overflow   (ovf),
    .neg_flag   (neg),
    .zero_flag  (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sgn;
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    logic        ovf;
    logic        neg;
    logic        zero;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Done pulse counter and busy/done exclusion, sampled mid-cycle.
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    n_cmp++;
    if (busy === 1'b1 && done === 1'b1) begin
      n_bad++;
      $display("FAIL busy_done_overlap: got busy=1 done=1 expected not both");
    end
  end

  // Issue one op from IDLE; returns edges from accept to done, or -1 on timeout.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s, output int lat);
    int d0;
    d0     = done_cnt;
    a_in   = a;
    b_in   = b;
    sgn_in = s;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
    chk("busy_low_at_done", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("done_count", done_cnt - d0, 32'd1);
  endtask

  function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic s,
                                output logic [15:0] q, output logic [15:0] r);
    logic signed [15:0] sa;
    logic signed [15:0] sb;
    sa = a;
    sb = b;
    if (b == 16'h0000) begin
      q = 16'hFFFF;
      r = a;
    end else if (s && a == 16'h8000 && b == 16'hFFFF) begin
      q = 16'h8000;
      r = 16'h0000;
    end else if (s) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  initial begin
    int lat;
    int d0;
    int n;
    logic [15:0] eq;
    logic [15:0] er;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rs;

    n_cmp = 0; n_bad = 0; done_cnt = 0;
    rst = 1'b1; start = 1'b0; a_in = 16'h0000; b_in = 16'h0000; sgn_in = 1'b0;

    vecs[0]  = '{16'd100,  16'd7,    1'b0, 16'h000E, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 17};
    vecs[1]  = '{16'hFFF9, 16'h0002, 1'b1, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 17};
    vecs[2]  = '{16'hFFF9, 16'h0002, 1'b0, 16'h7FFC, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 17};
    vecs[3]  = '{16'h1234, 16'h0000, 1'b0, 16'hFFFF, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    vecs[4]  = '{16'd100,  16'd7,    1'b0, 16'h000E, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 17};
    vecs[5]  = '{16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 17};
    vecs[6]  = '{16'h8000, 16'hFFFF, 1'b0, 16'h0000, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b1, 17};
    vecs[7]  = '{16'h0007, 16'hFFFE, 1'b1, 16'hFFFD, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0, 17};
    vecs[8]  = '{16'h0005, 16'h0009, 1'b0, 16'h0000, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b1, 17};
    vecs[9]  = '{16'hFFFF, 16'hFFFF, 1'b0, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 17};
    vecs[10] = '{16'h8000, 16'h0001, 1'b1, 16'h8000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 17};
    vecs[11] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_quot", {16'd0, quot}, 32'd0);
    chk("reset_rem",  {16'd0, rem},  32'd0);
    chk("reset_flags", {28'd0, dz, ovf, neg, zero}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sgn, lat);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_quot", i), {16'd0, quot}, {16'd0, vecs[i].q});
      chk($sformatf("v%0d_rem", i),  {16'd0, rem},  {16'd0, vecs[i].r});
      chk($sformatf("v%0d_flags", i), {28'd0, dz, ovf, neg, zero},
          {28'd0, vecs[i].dz, vecs[i].ovf, vecs[i].neg, vecs[i].zero});
    end

    // start re-pulsed at edge 5 with different operands must be ignored.
    d0 = done_cnt;
    a_in = 16'd1000; b_in = 16'd3; sgn_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    a_in = 16'd50; b_in = 16'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (n = 6; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
    chk("repulse_latency", lat, 32'd17);
    chk("repulse_quot", {16'd0, quot}, 32'h0000014D);
    chk("repulse_rem",  {16'd0, rem},  32'h00000001);
    repeat (6) @(posedge clk);
    #1;
    chk("repulse_single_done", done_cnt - d0, 32'd1);

    // Reset at edge 9 drops the operation in flight.
    d0 = done_cnt;
    a_in = 16'h4321; b_in = 16'h0011; sgn_in = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_quot", {16'd0, quot}, 32'd0);
    chk("midrst_rem",  {16'd0, rem},  32'd0);
    chk("midrst_flags", {28'd0, dz, ovf, neg, zero}, 32'd0);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("midrst_no_done", done_cnt - d0, 32'd0);
    run_op(16'h4321, 16'h0011, 1'b1, lat);
    chk("postrst_latency", lat, 32'd17);
    chk("postrst_quot", {16'd0, quot}, 32'h000003F2);
    chk("postrst_rem",  {16'd0, rem},  32'h0000000F);

    for (int i = 0; i < 500; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom_range(0, 1));
      if (i % 50 == 7)  rb = 16'h0000;
      if (i % 40 == 3)  rb = 16'($urandom_range(1, 9));
      if (i % 97 == 11) begin ra = 16'h8000; rb = 16'hFFFF; end
      model(ra, rb, rs, eq, er);
      run_op(ra, rb, rs, lat);
      chk($sformatf("rnd%0d_quot a=%h b=%h s=%0d", i, ra, rb, rs), {16'd0, quot}, {16'd0, eq});
      chk($sformatf("rnd%0d_rem a=%h b=%h s=%0d", i, ra, rb, rs),  {16'd0, rem},  {16'd0, er});
      chk($sformatf("rnd%0d_latency", i), lat, (rb == 16'h0000) ? 32'd1 : 32'd17);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
